// File: rtl/cpu_ctrl_pkg.sv
// Shared types, field positions and widths for the ALU control sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned ALU_W     = 12;
    localparam int unsigned IR_W      = 32;
    localparam int unsigned OPC_W     = 5;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_MSB  = 26;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_MSB  = 22;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_MSB  = 18;
    localparam int unsigned RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_FIRST_ALU = 5'd5;
    localparam logic [OPC_W-1:0] OP_SHR       = 5'd9;
    localparam logic [OPC_W-1:0] OP_LAST_ALU  = 5'd16;
    localparam logic [OPC_W-1:0] ALU_BASE     = 5'd5;

    typedef enum logic [2:0] {
        T0,
        T1,
        T2,
        T3,
        T4,
        T5
    } state_t;

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op >= OP_FIRST_ALU) && (op <= OP_LAST_ALU);
    endfunction

    // One-hot ALU select; returns zero for opcodes outside the ALU range.
    function automatic logic [ALU_W-1:0] alu_select(input logic [OPC_W-1:0] op);
        logic [OPC_W-1:0] idx;
        idx = op - ALU_BASE;
        if (!is_alu_op(op)) begin
            return '0;
        end
        return ALU_W'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index to one-hot select, all-zero when disabled.
module reg_select_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hard-wired fetch/execute sequencer producing bus datapath strobes for
// register-format ALU instructions.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [IR_W-1:0]     ir,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Yin,
    output logic                MDRRead,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic [ALU_W-1:0]    ALUControl,
    output logic                illegal_op,
    output logic                instr_done,
    output logic [15:0]         retired
);

    state_t        state_q, state_d;
    logic          wait_q, wait_d;
    logic [15:0]   retired_q, retired_d;

    logic [OPC_W-1:0]     opcode;
    logic [REG_IDX_W-1:0] ra, rb, rc;
    logic                 legal;
    logic                 unused_ir_bits;

    logic [REG_IDX_W-1:0] rout_idx;
    logic                 rout_en;
    logic                 rin_en;

    assign opcode         = ir[OPC_MSB:OPC_LSB];
    assign ra             = ir[RA_MSB:RA_LSB];
    assign rb             = ir[RB_MSB:RB_LSB];
    assign rc             = ir[RC_MSB:RC_LSB];
    assign legal          = is_alu_op(opcode);
    assign unused_ir_bits = ^ir[RC_LSB-1:0];
    assign retired        = retired_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= T0;
            wait_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // wait_q marks T1 cycles after the first, so PC is loaded only once.
    always_comb begin
        state_d   = state_q;
        wait_d    = 1'b0;
        retired_d = retired_q;
        case (state_q)
            T0: if (run) state_d = T1;
            T1: begin
                if (mem_ready) begin
                    state_d = T2;
                end else begin
                    wait_d = 1'b1;
                end
            end
            T2: state_d = T3;
            T3: state_d = legal ? T4 : T0;
            T4: state_d = T5;
            T5: begin
                state_d   = T0;
                retired_d = retired_q + 16'd1;
            end
            default: state_d = T0;
        endcase
    end

    // Every strobe is gated by clr so reset drops them without a clock edge.
    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        PCin       = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Yin        = 1'b0;
        MDRRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        ALUControl = '0;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        rout_en    = 1'b0;
        rout_idx   = rb;
        rin_en     = 1'b0;
        if (!clr) begin
            case (state_q)
                T0: begin
                    if (run) begin
                        PCout = 1'b1;
                        MARin = 1'b1;
                        IncPC = 1'b1;
                        Zin   = 1'b1;
                    end
                end
                T1: begin
                    Zlowout = 1'b1;
                    PCin    = !wait_q;
                    MDRRead = 1'b1;
                    MDRin   = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                T3: begin
                    if (legal) begin
                        rout_en = 1'b1;
                        Yin     = 1'b1;
                    end else begin
                        illegal_op = 1'b1;
                    end
                end
                T4: begin
                    rout_en    = 1'b1;
                    rout_idx   = rc;
                    ALUControl = alu_select(opcode);
                    Zin        = 1'b1;
                end
                T5: begin
                    Zlowout    = 1'b1;
                    rin_en     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    reg_select_decoder u_rout_dec (
        .idx (rout_idx),
        .en  (rout_en),
        .sel (Rout)
    );

    reg_select_decoder u_rin_dec (
        .idx (ra),
        .en  (rin_en),
        .sel (Rin)
    );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized self-checking bench for alu_control_sequencer against a
// per-instruction phase model.
module tb_alu_control_sequencer;

    logic        clk;
    logic        clr;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [15:0] Rout, Rin;
    logic        PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin;
    logic        MDRRead, MDRin, MDRout, IRin;
    logic [11:0] ALUControl;
    logic        illegal_op, instr_done;
    logic [15:0] retired;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_retired;

    localparam logic [12:0] S_PCOUT   = 13'h1000;
    localparam logic [12:0] S_MARIN   = 13'h0800;
    localparam logic [12:0] S_INCPC   = 13'h0400;
    localparam logic [12:0] S_PCIN    = 13'h0200;
    localparam logic [12:0] S_ZIN     = 13'h0100;
    localparam logic [12:0] S_ZLOW    = 13'h0080;
    localparam logic [12:0] S_YIN     = 13'h0040;
    localparam logic [12:0] S_MDRREAD = 13'h0020;
    localparam logic [12:0] S_MDRIN   = 13'h0010;
    localparam logic [12:0] S_MDROUT  = 13'h0008;
    localparam logic [12:0] S_IRIN    = 13'h0004;
    localparam logic [12:0] S_ILL     = 13'h0002;
    localparam logic [12:0] S_DONE    = 13'h0001;

    logic [56:0] out_vec;
    assign out_vec = {Rout, Rin, ALUControl, PCout, MARin, IncPC, PCin, Zin,
                      Zlowout, Yin, MDRRead, MDRin, MDRout, IRin,
                      illegal_op, instr_done};

    alu_control_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .Rout       (Rout),
        .Rin        (Rin),
        .PCout      (PCout),
        .MARin      (MARin),
        .IncPC      (IncPC),
        .PCin       (PCin),
        .Zin        (Zin),
        .Zlowout    (Zlowout),
        .Yin        (Yin),
        .MDRRead    (MDRRead),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op),
        .instr_done (instr_done),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [56:0] mk(input logic [15:0] rout, input logic [15:0] rin,
                                       input logic [11:0] alu, input logic [12:0] s);
        return {rout, rin, alu, s};
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] k);
        logic [15:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] alu_bit(input logic [4:0] op);
        logic [11:0] v;
        int          k;
        v = '0;
        k = int'(op) - 5;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            run       = 1'b0;
            mem_ready = 1'($urandom % 2);
            ir        = $urandom;
            #1 check("idle", out_vec, '0);
        end
    endtask

    // One instruction from T0 back to T0, checking every cycle; optionally
    // asserts clr in the middle of T4.
    task automatic do_instr(input logic [31:0] instr, input int nwait, input bit abort_t4);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         legal;
        op    = instr[31:27];
        ra    = instr[26:23];
        rb    = instr[22:19];
        rc    = instr[18:15];
        legal = (op >= 5'd5) && (op <= 5'd16);

        @(negedge clk);
        run       = 1'b1;
        mem_ready = 1'($urandom % 2);
        ir        = instr;
        #1 check("t0", out_vec, mk('0, '0, '0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN));
        check("t0_retired", 64'(retired), 64'(exp_retired));

        for (int w = 0; w <= nwait; w++) begin
            @(negedge clk);
            run       = 1'($urandom % 2);
            mem_ready = (w == nwait);
            #1 check("t1", out_vec,
                     mk('0, '0, '0, S_ZLOW | S_MDRREAD | S_MDRIN | ((w == 0) ? S_PCIN : 13'h0)));
        end

        @(negedge clk);
        run       = 1'($urandom % 2);
        mem_ready = 1'($urandom % 2);
        #1 check("t2", out_vec, mk('0, '0, '0, S_MDROUT | S_IRIN));

        @(negedge clk);
        run       = 1'($urandom % 2);
        mem_ready = 1'($urandom % 2);
        if (legal) begin
            #1 check("t3", out_vec, mk(onehot16(rb), '0, '0, S_YIN));
        end else begin
            #1 check("t3_illegal", out_vec, mk('0, '0, '0, S_ILL));
            return;
        end

        @(negedge clk);
        run       = 1'($urandom % 2);
        mem_ready = 1'($urandom % 2);
        #1 check("t4", out_vec, mk(onehot16(rc), '0, alu_bit(op), S_ZIN));
        if (abort_t4) begin
            #1 clr = 1'b1;
            #1 check("abort_t4_outputs", out_vec, '0);
            check("abort_t4_retired", 64'(retired), 64'h0);
            @(posedge clk);
            #1 check("abort_held", out_vec, '0);
            @(negedge clk);
            clr         = 1'b0;
            run         = 1'b0;
            exp_retired = '0;
            #1 check("post_abort_idle", out_vec, '0);
            check("post_abort_retired", 64'(retired), 64'h0);
            return;
        end

        @(negedge clk);
        run       = 1'($urandom % 2);
        mem_ready = 1'($urandom % 2);
        #1 check("t5", out_vec, mk('0, onehot16(ra), '0, S_ZLOW | S_DONE));
        exp_retired = exp_retired + 16'd1;
    endtask

    initial begin
        logic [31:0] x;
        logic [4:0]  op;
        n_checks    = 0;
        n_fail      = 0;
        exp_retired = '0;
        clr         = 1'b1;
        run         = 1'b1;
        mem_ready   = 1'b1;
        ir          = 32'h4A920000;

        #2 check("reset_outputs", out_vec, '0);
        check("reset_retired", 64'(retired), 64'h0);
        @(posedge clk);
        #1 check("reset_held", out_vec, '0);
        @(negedge clk);
        clr = 1'b0;
        run = 1'b0;

        idle(10);

        // shr R5,R2,R4 with no wait states, then with three
        do_instr(32'h4A920000, 0, 1'b0);
        do_instr(32'h4A920000, 3, 1'b0);
        do_instr(32'h00000000, 0, 1'b0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            x  = $urandom;
            op = ($urandom % 4 == 0) ? 5'($urandom % 32) : 5'(5 + $urandom % 12);
            x[31:27] = op;
            do_instr(x, int'($urandom % 4), 1'b0);
            if ($urandom % 5 == 0) idle(1 + int'($urandom % 2));
        end

        do_instr(32'h4A920000, 1, 1'b1);
        do_instr(32'h4A920000, 0, 1'b0);

        @(negedge clk);
        run = 1'b0;
        force dut.retired_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_q;
        exp_retired = 16'hFFFE;
        #1 check("preload_retired", 64'(retired), 64'hFFFE);
        do_instr(32'h4A920000, 0, 1'b0);
        do_instr({5'd16, 4'd15, 4'd0, 4'd15, 15'h0}, 2, 1'b0);
        do_instr({5'd17, 27'h0}, 0, 1'b0);
        idle(2);
        check("wrap_retired", 64'(retired), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
